// File: rtl/inst_loader_pkg.sv
// inst_loader shared definitions: defaults and FSM state encoding.
// Imported by the loader and the pipeline top so address widths agree.
package inst_loader_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DEPTH_DEF = 1024;
    localparam logic [7:0] SYNC_DEF = 8'hA5;
    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_e;

endpackage

// File: rtl/inst_loader_if.sv
// inst_loader byte-stream handshake bundle.
// The serial receiver is the master, the loader is the slave.
interface inst_loader_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/inst_loader_word_assembler.sv
// inst_loader word assembler: big-endian byte shifter,
// byte index and running XOR checksum, all cleared together.
module word_assembler (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_nxt_o,
    output logic        last_o,
    output logic [7:0]  chk_o
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;
    logic [7:0]  chk_q;

    assign word_nxt_o = {word_q[23:0], byte_i};
    assign last_o = en_i && shift_i && (idx_q == 2'd3);
    assign chk_o = chk_q;

    // Checksum and shift share the accepted-byte qualifier en_i.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
            chk_q  <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            idx_q  <= '0;
            chk_q  <= '0;
        end else if (en_i) begin
            chk_q <= chk_q ^ byte_i;
            if (shift_i) begin
                word_q <= word_nxt_o;
                idx_q  <= idx_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// inst_loader top: framed byte loader writing instruction memory.
// Holds the CPU halted while a frame is in flight.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEF
) (
    input  logic              clock,
    input  logic              rst_n,
    inst_loader_if.slave      rx,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ADDR_W:0]    wc_q, wc_d, wc_inc;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept;
    logic               clr, en, shift;
    logic [31:0]        word_nxt;
    logic               last;
    logic [7:0]         chk;

    assign rx.rx_ready = (state_q != S_WRITE);
    assign accept = rx.rx_valid && rx.rx_ready;
    assign wc_inc = wc_q + 1'b1;

    assign mem_address = addr_q;
    assign mem_data = data_q;
    assign mem_wren = (state_q == S_WRITE);
    assign cpu_hold = hold_q;
    assign load_done = done_q;
    assign load_error = err_q;
    assign word_count = wc_q;

    word_assembler u_asm (
        .clock      (clock),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .en_i       (en),
        .shift_i    (shift),
        .byte_i     (rx.rx_data),
        .word_nxt_o (word_nxt),
        .last_o     (last),
        .chk_o      (chk)
    );

    // State and datapath registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            wc_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wc_q    <= wc_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Frame parser: next state, status flags and assembler controls.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wc_d    = wc_q;
        addr_d  = addr_q;
        data_d  = data_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        clr     = 1'b0;
        en      = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (accept && rx.rx_data == SYNC_BYTE) begin
                    state_d = S_LEN_HI;
                    clr     = 1'b1;
                    wc_d    = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    en      = 1'b1;
                    len_d   = {rx.rx_data, 8'h00};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    en    = 1'b1;
                    len_d = {len_q[15:8], rx.rx_data};
                    if (len_d == '0) begin
                        state_d = S_CHECK;
                    end else if (len_d > LEN_W'(DEPTH)) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    en    = 1'b1;
                    shift = 1'b1;
                    if (last) begin
                        addr_d  = wc_q[ADDR_W-1:0];
                        data_d  = word_nxt;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                wc_d = wc_inc;
                if (LEN_W'(wc_inc) == len_q) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (rx.rx_data == chk) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Byte-stream program loader that writes 32-bit instructions into the instruction memory consumed by `mips_pipeline`. It takes framed bytes from a serial receiver over a valid/ready handshake and assembles them big-endian into words. It writes each word to consecutive instruction addresses starting at 0, verifies an XOR checksum, and holds the CPU in halt for the whole load.

## Interface
Parameters:
- `ADDR_W`, 10: instruction memory address width; matches the 10-bit PC.
- `DEPTH`, 1024: maximum word count accepted; must be ≤ 2^ADDR_W.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clock`  in  1  system clock (same clock as instruction memory).
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader can accept a byte.
- `mem_address`  out  ADDR_W  instruction memory write address.
- `mem_data`  out  32  instruction word to write.
- `mem_wren`  out  1  one-cycle write strobe.
- `cpu_hold`  out  1  keeps the pipeline halted and its PC at 0 while asserted.
- `load_done`  out  1  last frame loaded with a good checksum.
- `load_error`  out  1  last frame failed (bad checksum or length > DEPTH).
- `word_count`  out  ADDR_W+1  words written in the current or last frame.

## Operation
- Frame format: `SYNC_BYTE`, LEN_HI, LEN_LO, then 4·LEN data bytes (MSB first per word), then CHK.
- CHK is the XOR of every byte after SYNC, including both length bytes.
- Byte transfer happens only on a cycle where `rx_valid && rx_ready`.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERROR.
- IDLE / DONE / ERROR: non-SYNC bytes are accepted and discarded. A SYNC byte moves to LEN_HI, clears the checksum, `word_count`, byte index, `load_done` and `load_error`, and sets `cpu_hold`=1.
- LEN_HI → LEN_LO → then:
  - LEN=0 goes to CHECK.
  - LEN>DEPTH goes to ERROR immediately.
  - Otherwise goes to DATA.
- DATA: bytes shift into a 32-bit assembly register, first byte ending up in [31:24]. After the 4th byte, go to WRITE.
- WRITE (exactly 1 cycle):
  - `mem_wren`=1, `mem_address`=`word_count`[ADDR_W-1:0], `mem_data`=assembled word, `rx_ready`=0.
  - `word_count` increments at the end of the cycle.
  - Next state is CHECK if `word_count`+1 == LEN, else DATA.
- CHECK: the next byte is compared with the running XOR. Match → DONE (`load_done`=1, `cpu_hold`=0). Mismatch → ERROR (`load_error`=1, `cpu_hold` stays 1).
- `rx_ready`=1 in every state except WRITE.
- `mem_wren`=0 outside WRITE. `mem_address`/`mem_data` hold their last value.
- Reset values: state IDLE, `rx_ready` 1, `mem_wren` 0, `mem_address` 0, `mem_data` 0, `cpu_hold` 0 (preloaded ROM image runs), `load_done` 0, `load_error` 0, `word_count` 0.

## Timing
- Write latency: `mem_wren` pulses in the cycle after the 4th byte of a word is accepted.
- Throughput: at most 1 word per 5 cycles with back-to-back bytes.
- `load_done`/`cpu_hold` change in the cycle after CHK is accepted.
- SYNC byte mid-frame (LEN/DATA/CHECK) is treated as data, not a restart.
- Addresses never wrap: LEN ≤ DEPTH is guaranteed by the ERROR check.
- `rx_valid` dropping mid-word: the byte index and the partial word are held indefinitely; there is no timeout.
- `rst_n` low mid-frame: everything returns to reset values asynchronously, and `cpu_hold` drops. The partially written memory is left as-is, and the CPU reset (KEY[0]) is sequenced externally.
- Checksum update and byte shift use the same accepted-byte qualifier. There is no double count on a stalled `rx_valid`.

## Structure
- A shared package holds the state encoding, `SYNC_BYTE`, `ADDR_W` and `DEPTH` defaults, so the pipeline top and the loader agree on address width.
- One sub-module: `word_assembler` (byte shift register + 2-bit byte index + running XOR, with a clear input). The FSM stays in `inst_loader`.

## Test plan
- Frame A5 00 01 20 08 00 05 2C → one `mem_wren` at address 0 with data 0x20080005; `load_done`=1; `cpu_hold` 1→0; `word_count`=1.
- Same frame with CHK=2D → no `load_done`; `load_error`=1; `cpu_hold` stays 1. A following correct frame clears the error.
- A5 04 01 … (LEN=1025) → ERROR right after LEN_LO; no writes occur.
- A5 00 00 00 → zero-length frame: `load_done`=1; `word_count`=0; no `mem_wren`.
- Three-word frame with `rx_valid` toggled randomly → writes at addresses 0,1,2 with correct words; `rx_ready`=0 only in the WRITE cycles.
- `rst_n` pulsed low after the 2nd data byte → all outputs at reset values; a new frame then loads from address 0.
